seq_divider: RTL and testbench

Sequential unsigned restoring divider. It computes an N-bit quotient and an N-bit remainder from an N-bit dividend and an N-bit divisor, one bit per shift/subtract step pair. It is the division counterpart of the team's shift-add sequential multiplier and uses the same start/ready handshake style. It consists of an N+1-bit partial-remainder datapath and a small control FSM with a down-counter.

---
 rtl/div_pkg.sv | 8 +
 rtl/div_sequencer.sv | 72 +++++++
 rtl/seq_divider.sv | 70 +++++++
 tb/tb_seq_divider.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} div_state_t;

    localparam int DIV_N_DEFAULT = 4;

endpackage

// File: rtl/div_sequencer.sv
// Control FSM for seq_divider: steps N shift/subtract pairs with a down-counter
// and issues the datapath strobes.
module div_sequencer
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic clock,
    input  logic n_rst,
    input  logic start,
    input  logic divisor_zero,
    input  logic neg,
    output logic load,
    output logic shift,
    output logic sub,
    output logic ready,
    output logic busy
);

    localparam int CW = $clog2(N + 1);

    div_state_t    state;
    div_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        shift      = 1'b0;
        sub        = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    cnt_next   = CW'(N);
                    state_next = divisor_zero ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift      = 1'b1;
                state_next = SUB;
            end
            SUB: begin
                // sub commits the difference; a negative result restores by doing nothing
                sub        = !neg;
                cnt_next   = cnt - CW'(1);
                state_next = (cnt == CW'(1)) ? DONE : SHIFT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == DONE);
    assign busy  = (state == SHIFT) || (state == SUB);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: N+1-bit partial remainder A, quotient
// register Q and divisor M, one quotient bit per SHIFT/SUB pair.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clock,
    input  logic         n_rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         ready,
    output logic         busy,
    output logic         div_by_zero
);

    logic [N:0]   a_reg;
    logic [N-1:0] q_reg;
    logic [N-1:0] m_reg;
    logic         dz;
    logic [N:0]   diff;
    logic         divisor_zero;
    logic         load;
    logic         shift;
    logic         sub;

    assign divisor_zero = (divisor == '0);
    assign diff         = a_reg - {1'b0, m_reg};

    div_sequencer #(.N(N)) u_sequencer (
        .clock       (clock),
        .n_rst       (n_rst),
        .start       (start),
        .divisor_zero(divisor_zero),
        .neg         (diff[N]),
        .load        (load),
        .shift       (shift),
        .sub         (sub),
        .ready       (ready),
        .busy        (busy)
    );

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            a_reg <= '0;
            q_reg <= '0;
            m_reg <= '0;
            dz    <= 1'b0;
        end else if (load) begin
            a_reg <= '0;
            q_reg <= dividend;
            m_reg <= divisor;
            dz    <= divisor_zero;
        end else if (shift) begin
            {a_reg, q_reg} <= {a_reg[N-1:0], q_reg, 1'b0};
        end else if (sub) begin
            a_reg    <= diff;
            q_reg[0] <= 1'b1;
        end
    end

    // A zero divisor skips the iteration, so Q still holds the captured dividend.
    assign quotient    = dz ? '1 : q_reg;
    assign remainder   = dz ? q_reg : a_reg[N-1:0];
    assign div_by_zero = ready & dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): stimulus pushes expected results
// into a queue, a negedge monitor pops and compares whenever a new result is shown.
module tb_seq_divider;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         n_rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         ready;
    logic         busy;
    logic         div_by_zero;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   fresh = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    seq_divider #(.N(N)) dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        else
            n_pass++;
    endtask

    // Reference: plain integer division; a zero divisor yields all-ones and the dividend.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.a = N'(a);
        e.b = N'(b);
        if (b == 0) begin
            e.q  = '1;
            e.r  = N'(a);
            e.dz = 1'b1;
        end else begin
            e.q  = N'(a / b);
            e.r  = N'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compare the displayed result once per accepted operation.
    always @(negedge clock) begin
        if (!n_rst) begin
            fresh = 1'b0;
        end else begin
            if (ready && fresh) begin
                fresh = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("quotient %0d/%0d", mon_e.a, mon_e.b), quotient, mon_e.q);
                    check($sformatf("remainder %0d/%0d", mon_e.a, mon_e.b), remainder, mon_e.r);
                    check($sformatf("div_by_zero %0d/%0d", mon_e.a, mon_e.b), div_by_zero, mon_e.dz);
                end
            end
            if (start && !busy)
                fresh = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        if (busy)
            check("idle_timeout", busy, 0);
    endtask

    // Returns at #1 after the accepting edge with start already released.
    task automatic issue(input int a, input int b);
        wait_idle();
        dividend = N'(a);
        divisor  = N'(b);
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        tick();
        start = 1'b0;
    endtask

    // Counts edges until ready and busy cycles seen on the way.
    task automatic await_result(input int exp_lat, input int exp_busy);
        int lat = 0;
        int nb  = busy ? 1 : 0;
        while (!ready && lat < 40) begin
            tick();
            lat++;
            if (busy)
                nb++;
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", nb, exp_busy);
    endtask

    task automatic run(input int a, input int b);
        issue(a, b);
        await_result((b == 0) ? 0 : 2 * N, (b == 0) ? 0 : 2 * N);
    endtask

    initial begin
        n_rst    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check("reset_ready", ready, 0);
        check("reset_busy", busy, 0);
        check("reset_div_by_zero", div_by_zero, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        n_rst = 1'b1;
        tick();

        run(13, 3);
        run(15, 1);
        run(5, 7);
        run(15, 15);
        run(0, 9);
        run(9, 0);

        // Start pulsed while busy must not disturb the operation in flight.
        issue(13, 3);
        repeat (3) tick();
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        await_result(4, 4);

        // Back-to-back from DONE: ready drops right after the reload edge.
        issue(14, 4);
        check("ready_drop_after_restart", ready, 0);
        await_result(2 * N, 2 * N);

        // Reset during SUB discards the partial result immediately.
        issue(13, 3);
        tick();
        check("midop_busy_before_reset", busy, 1);
        n_rst = 1'b0;
        #1;
        check("midop_reset_ready", ready, 0);
        check("midop_reset_busy", busy, 0);
        check("midop_reset_div_by_zero", div_by_zero, 0);
        check("midop_reset_quotient", quotient, 0);
        check("midop_reset_remainder", remainder, 0);
        exp_q.delete();
        tick();
        n_rst = 1'b1;
        tick();
        run(11, 2);

        // start held high: one ready pulse per accepted operation.
        wait_idle();
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        exp_q.push_back(model(7, 2));
        for (int i = 0; i < 3; i++) begin
            int na;
            int nb;
            tick();
            if (i > 0)
                check("held_start_ready_pulse", ready, 0);
            na = $urandom_range(0, 15);
            nb = $urandom_range(1, 15);
            if (i < 2) begin
                dividend = N'(na);
                divisor  = N'(nb);
                exp_q.push_back(model(na, nb));
            end else begin
                start = 1'b0;
            end
            await_result(2 * N, 2 * N);
        end
        tick();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run(a, b);
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        for (int i = 0; i < 40; i++) begin
            run($urandom_range(0, 15), $urandom_range(0, 15));
            repeat ($urandom_range(0, 1)) tick();
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
